// File: rtl/pkg_wishbone_peri_uart.sv
// Shared definitions for the Wishbone UART peripheral: bus structs, register map,
// STATUS bit positions and the shifter state encoding used by both directions.
package pkg_wishbone_peri_uart;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;

    localparam int unsigned ST_RX_NONEMPTY  = 0;
    localparam int unsigned ST_TX_FULL      = 1;
    localparam int unsigned ST_TX_IDLE      = 2;
    localparam int unsigned ST_RX_OVERRUN   = 3;
    localparam int unsigned ST_RX_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } shift_state_e;

    typedef struct packed {
        logic       stb;
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } wb_ctrl_t;

    typedef struct packed {
        logic       ack;
        logic [7:0] dat;
        logic       stall;
    } wb_peri_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word-fall-through read data; pointers carry one extra wrap bit.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/wishbone_peri_uart.sv
// Wishbone responder exposing a buffered 8N1 UART: DATA/STATUS registers, TX and RX
// shifters inline, one FIFO per direction and sticky overrun / framing-error flags.
module wishbone_peri_uart
    import pkg_wishbone_peri_uart::*;
#(
    parameter int unsigned CLK_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  wb_ctrl_t wb_c,
    output wb_peri_t wb_p,
    output logic     tx,
    input  logic     rx
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    logic       ack_q, ack_d;
    logic [7:0] rdat_q, rdat_d;
    logic       wr_pend_q, wr_pend_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] status;
    logic       bus_rd, bus_wr, sts_wr;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_rdata;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_rdata;
    logic       overrun_set, frame_err_set;

    shift_state_e      tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              tx_bit_end;

    logic              rx_sync1_q, rx_sync2_q, rx_prev_q;
    shift_state_e      rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_bit_end;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (wr_data_q),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_shift_q),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Bus side: every strobe is accepted; ack and read data are registered.
    always_comb begin
        bus_rd  = wb_c.stb && !wb_c.we;
        bus_wr  = wb_c.stb && wb_c.we;
        sts_wr  = bus_wr && (wb_c.adr == ADR_STATUS);
        rx_pop  = bus_rd && (wb_c.adr == ADR_DATA) && !rx_empty;
        // Full is sampled from registered state, so a same-cycle shifter pop does not help.
        tx_push = wr_pend_q && !tx_full;

        status                  = 8'h00;
        status[ST_RX_NONEMPTY]  = !rx_empty;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_IDLE]      = tx_empty && (tx_state_q == StIdle);
        status[ST_RX_OVERRUN]   = overrun_q;
        status[ST_RX_FRAME_ERR] = frame_err_q;

        ack_d  = wb_c.stb;
        rdat_d = 8'h00;
        if (bus_rd) begin
            unique case (wb_c.adr)
                ADR_DATA:   rdat_d = rx_empty ? 8'h00 : rx_rdata;
                ADR_STATUS: rdat_d = status;
                default:    rdat_d = 8'h00;
            endcase
        end
        wr_pend_d = bus_wr && (wb_c.adr == ADR_DATA);
        wr_data_d = wb_c.dat;

        overrun_set = rx_push && rx_full && !rx_pop;
        overrun_d   = (overrun_q && !(sts_wr && wb_c.dat[ST_RX_OVERRUN])) || overrun_set;
        frame_err_d = (frame_err_q && !(sts_wr && wb_c.dat[ST_RX_FRAME_ERR])) || frame_err_set;
    end

    // TX shifter; a queued byte's start bit follows the stop bit with no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_bit_end = (tx_cnt_q == BIT_LAST);
        if (tx_state_q != StIdle) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        end
        unique case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_rdata;
                    tx_cnt_d   = '0;
                    tx_state_d = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (tx_bit_end) begin
                    tx_state_d = StData;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end
            end
            StData: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            StStop: begin
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_state_d = StStart;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = StIdle;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    // RX shifter: start is re-checked at mid-bit, later samples land on bit centres.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q + CW'(1);
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        rx_bit_end    = (rx_cnt_q == BIT_LAST);
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (rx_bit_end) begin
                    rx_state_d    = StIdle;
                    rx_push       = rx_sync2_q;
                    frame_err_set = !rx_sync2_q;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q       <= 1'b0;
            rdat_q      <= 8'h00;
            wr_pend_q   <= 1'b0;
            wr_data_q   <= 8'h00;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            tx_q        <= 1'b1;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
        end else begin
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            wr_pend_q   <= wr_pend_d;
            wr_data_q   <= wr_data_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_sync1_q  <= rx;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    assign wb_p = '{ack: ack_q, dat: rdat_q, stall: 1'b0};
    assign tx   = tx_q;

endmodule

// File: tb/tb_wishbone_peri_uart.sv
// Scoreboard bench: expected read data and TX bytes are queued as stimulus is driven
// and retired by monitors on the bus response and the serial line.
module tb_wishbone_peri_uart;
    import pkg_wishbone_peri_uart::*;

    localparam int unsigned CPB = 4;

    logic     clk;
    logic     rst;
    wb_ctrl_t wb_c;
    wb_peri_t wb_p;
    logic     tx;
    logic     rx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int tx_exp[$];
    int tx_starts[$];
    logic mon_stb;

    wishbone_peri_uart #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .wb_c (wb_c),
        .wb_p (wb_p),
        .tx   (tx),
        .rx   (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: ack must follow every strobe by one cycle; reads retire queued data.
    always @(posedge clk) begin
        mon_stb = wb_c.stb && rst;
        #1;
        check_eq("ack", wb_p.ack, mon_stb);
        if (wb_p.ack) begin
            if (exp_q.size() == 0) begin
                check_eq("bus_queue", exp_q.size(), 1);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e >= 0) check_eq("rd_data", wb_p.dat, e);
            end
        end
    end

    // Serial monitor: decodes 8N1 frames at bit centres and matches queued bytes.
    initial begin
        forever begin
            tick1();
            if (rst && tx === 1'b0) begin
                int st;
                int exp_b;
                logic [7:0] b;
                st = cyc;
                repeat (2) tick1();
                check_eq("tx_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick1();
                    b[i] = tx;
                end
                repeat (CPB) tick1();
                check_eq("tx_stop_bit", tx, 1);
                exp_b = (tx_exp.size() != 0) ? tx_exp.pop_front() : 'h100;
                check_eq("tx_byte", b, exp_b);
                tx_starts.push_back(st);
                tick1();
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                           input int exp, output int edge_no);
        @(negedge clk);
        wb_c.stb = 1'b1;
        wb_c.we  = we;
        wb_c.adr = adr;
        wb_c.dat = dat;
        exp_q.push_back(exp);
        edge_no = cyc + 1;
    endtask

    task automatic wb_idle();
        @(negedge clk);
        wb_c.stb = 1'b0;
        wb_c.we  = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int e;
        int wr_edge;
        int a1_edge;
        wb_c = '0;
        rx   = 1'b1;
        rst  = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_dat", wb_p.dat, 0);
        rst = 1'b1;

        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h04, e);
        wb_idle();

        // Single byte: start bit two edges after acceptance.
        tx_starts.delete();
        tx_exp.push_back(8'h55);
        wb_xfer(1'b1, ADR_DATA, 8'h55, -1, wr_edge);
        wb_idle();
        repeat (44) @(negedge clk);
        check_eq("tx_55_seen", tx_starts.size(), 1);
        if (tx_starts.size() != 0) check_eq("tx_latency", tx_starts[0] - wr_edge, 2);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h04, e);
        wb_idle();

        // Burst of six writes: five fit (one in the shifter, four queued), the sixth drops.
        tx_starts.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_exp.push_back(8'hA1 + i);
            wb_xfer(1'b1, ADR_DATA, 8'(8'hA1 + i), -1, wr_edge);
            if (i == 0) a1_edge = wr_edge;
        end
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h02, e);
        wb_idle();
        repeat (5 * 10 * CPB + 10) @(negedge clk);
        check_eq("tx_burst_frames", tx_starts.size(), 5);
        if (tx_starts.size() == 5) begin
            check_eq("tx_burst_latency", tx_starts[0] - a1_edge, 2);
            for (int i = 1; i < 5; i++) check_eq("tx_gap", tx_starts[i] - tx_starts[i-1], 40);
        end
        check_eq("tx_exp_drained", tx_exp.size(), 0);

        // RX single byte.
        rx_frame(8'h3C, 1'b1);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h05, e);
        wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h3C, e);
        wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h00, e);
        wb_idle();

        // RX overrun: five frames into a four-deep FIFO; keep TX busy so tx_idle is 0.
        for (int i = 0; i < 5; i++) rx_frame(8'(8'h11 * (i + 1)), 1'b1);
        tx_exp.push_back(8'h5A);
        wb_xfer(1'b1, ADR_DATA, 8'h5A, -1, e);
        wb_idle();
        repeat (4) @(negedge clk);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h09, e);
        for (int i = 0; i < 4; i++) wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h11 * (i + 1), e);
        wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h00, e);
        wb_idle();
        repeat (50) @(negedge clk);
        wb_xfer(1'b1, ADR_STATUS, 8'h08, -1, e);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h04, e);
        wb_idle();

        // Framing error, then clear it.
        rx_frame(8'h77, 1'b0);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h14, e);
        wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h00, e);
        wb_xfer(1'b1, ADR_STATUS, 8'h10, -1, e);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h04, e);
        wb_idle();

        // One-cycle glitch on idle rx is rejected silently.
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        wb_xfer(1'b0, ADR_STATUS, 8'h00, 8'h04, e);
        wb_xfer(1'b0, ADR_DATA, 8'h00, 8'h00, e);
        wb_xfer(1'b0, 2'd2, 8'h00, 8'h00, e);
        wb_idle();

        repeat (10) @(negedge clk);
        check_eq("bus_exp_drained", exp_q.size(), 0);
        check_eq("tx_exp_final", tx_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
